// File: rtl/stopwatch_core.sv
// stopwatch_core - timing core of the digital stopwatch.
//
// Counts elapsed time as four BCD digits M:SS.t (max 9:59.9) and drives the
// free-running digit-scan strobe for the downstream 7-segment multiplexer.
// Owns the IDLE/RUN/STOP control FSM and both prescalers.
//
// Parameters:
//   DIV_TENTH  clk cycles per 0.1 s tick (>= 2)
//   DIV_SCAN   clk cycles per scan strobe (>= 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   r        in   asynchronous active-high reset
//   ss       in   start/stop request, 1-cycle pulse
//   clr      in   clear request, 1-cycle pulse (wins over ss)
//   lap      in   lap freeze toggle, 1-cycle pulse (LAP_EN builds only)
//   d0..d3   out  tenths, seconds units, seconds tens, minutes (BCD)
//   scan     out  1-cycle strobe every DIV_SCAN cycles
//   running  out  high while in RUN
//   ovf      out  high once the count saturated at 9:59.9, until clear
//
// Optional feature macro: LAP_EN (adds the lap input and a display snapshot).

module stopwatch_core #(
  parameter int unsigned DIV_TENTH = 5000000,
  parameter int unsigned DIV_SCAN  = 50000
) (
  input  logic       clk,
  input  logic       r,
  input  logic       ss,
  input  logic       clr,
`ifdef LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       scan,
  output logic       running,
  output logic       ovf
);

  localparam int unsigned TW = $clog2(DIV_TENTH);
  localparam int unsigned SW = $clog2(DIV_SCAN);
  localparam logic [TW-1:0] TMAX = TW'(DIV_TENTH - 1);
  localparam logic [SW-1:0] SMAX = SW'(DIV_SCAN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_scnt;
  logic          r_scan;
  logic          r_running;
  logic          r_ovf;
  logic [3:0]    r_c0, r_c1, r_c2, r_c3;
  logic [3:0]    w_c0, w_c1, w_c2, w_c3;
  logic          w_tick;
  logic          w_at_max;

  // ---------------------------------------------------------------------------
  // Scan prescaler: free-running, independent of the FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_scnt <= '0;
      r_scan <= 1'b0;
    end else begin
      r_scnt <= (r_scnt == SMAX) ? '0 : r_scnt + SW'(1);
      r_scan <= (r_scnt == SMAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    w_tick   = (r_state == RUN) && (r_tcnt == TMAX);
    w_at_max = (r_c3 == 4'd9) && (r_c2 == 4'd5) && (r_c1 == 4'd9) && (r_c0 == 4'd9);
    if (clr) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (ss) w_next = RUN;
        RUN: begin
          // Saturating tick forces STOP regardless of ss.
          if (w_tick && w_at_max) w_next = STOP;
          else if (ss)            w_next = STOP;
        end
        STOP: if (ss && !r_ovf) w_next = RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  // BCD cascade: each digit rolls over only when all lower digits roll over.
  always_comb begin
    w_c0 = r_c0;
    w_c1 = r_c1;
    w_c2 = r_c2;
    w_c3 = r_c3;
    if (r_c0 == 4'd9) begin
      w_c0 = 4'd0;
      if (r_c1 == 4'd9) begin
        w_c1 = 4'd0;
        if (r_c2 == 4'd5) begin
          w_c2 = 4'd0;
          w_c3 = r_c3 + 4'd1;
        end else begin
          w_c2 = r_c2 + 4'd1;
        end
      end else begin
        w_c1 = r_c1 + 4'd1;
      end
    end else begin
      w_c0 = r_c0 + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State, tenth prescaler, count and flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_c0      <= '0;
      r_c1      <= '0;
      r_c2      <= '0;
      r_c3      <= '0;
    end else begin
      r_state   <= w_next;
      // running tracks the state register exactly, so it is loaded from w_next.
      r_running <= (w_next == RUN);
      if (clr) begin
        r_tcnt <= '0;
        r_ovf  <= 1'b0;
        r_c0   <= '0;
        r_c1   <= '0;
        r_c2   <= '0;
        r_c3   <= '0;
      end else begin
        // Prescaler holds outside RUN so a pause keeps the fractional tenth.
        if (r_state == RUN) r_tcnt <= w_tick ? '0 : r_tcnt + TW'(1);
        if (w_tick) begin
          if (w_at_max) begin
            r_ovf <= 1'b1;
          end else begin
            r_c0 <= w_c0;
            r_c1 <= w_c1;
            r_c2 <= w_c2;
            r_c3 <= w_c3;
          end
        end
      end
    end
  end

  assign scan    = r_scan;
  assign running = r_running;
  assign ovf     = r_ovf;

`ifdef LAP_EN
  logic        r_frozen;
  logic [15:0] r_snap;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_frozen <= 1'b0;
      r_snap   <= '0;
    end else if (clr) begin
      r_frozen <= 1'b0;
    end else if (lap && (r_state != IDLE)) begin
      r_frozen <= ~r_frozen;
      if (!r_frozen) r_snap <= {r_c3, r_c2, r_c1, r_c0};
    end
  end

  assign {d3, d2, d1, d0} = r_frozen ? r_snap : {r_c3, r_c2, r_c1, r_c0};
`else
  assign {d3, d2, d1, d0} = {r_c3, r_c2, r_c1, r_c0};
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       r   = 1'b0;
  logic       ss  = 1'b0;
  logic       clr = 1'b0;
`ifdef LAP_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] d0, d1, d2, d3;
  logic       scan, running, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic        run;
    logic        ov;
    logic        sc_chk;
    logic        sc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  stopwatch_core #(.DIV_TENTH(4), .DIV_SCAN(3)) dut (
    .clk(clk),
    .r(r),
    .ss(ss),
    .clr(clr),
`ifdef LAP_EN
    .lap(lap),
`endif
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .scan(scan),
    .running(running),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string n, logic [15:0] d, logic run, logic ov);
    exp_t x;
    x.name = n; x.dig = d; x.run = run; x.ov = ov; x.sc_chk = 1'b0; x.sc = 1'b0;
    return x;
  endfunction

  // Advance n rising edges, leaving time 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    ss = 1'b1; cyc(1); ss = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 r = 1'b1;
    sb.push_back(mk("reset_state", 16'h0000, 1'b0, 1'b0));
    cyc(2);
    e = sb.pop_front(); checks++;
    if ({d3, d2, d1, d0, running, ovf, scan} !== {e.dig, e.run, e.ov, 1'b0}) begin
      errors++;
      $display("FAIL %s got %h run=%b ovf=%b scan=%b want %h run=%b ovf=%b scan=0",
               e.name, {d3, d2, d1, d0}, running, ovf, scan, e.dig, e.run, e.ov);
    end
    r = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_t x;
      x = mk($sformatf("idle_scan_c%0d", k), 16'h0000, 1'b0, 1'b0);
      x.sc_chk = 1'b1;
      x.sc = (k % 3 == 0);
      sb.push_back(x);
      cyc(1);
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf, scan} !== {e.dig, e.run, e.ov, e.sc}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b scan=%b want %h run=%b ovf=%b scan=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, scan, e.dig, e.run, e.ov, e.sc);
      end
    end
  endtask

  task automatic test_run();
    pulse_ss();
    sb.push_back(mk("run_9ticks", 16'h0009, 1'b1, 1'b0));
    sb.push_back(mk("run_10ticks", 16'h0010, 1'b1, 1'b0));
    sb.push_back(mk("run_clear", 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cyc(39);
      else if (i == 1) cyc(1);
      else pulse_clr();
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
  endtask

  task automatic test_saturate();
    pulse_ss();
    sb.push_back(mk("sat_0599", 16'h0599, 1'b1, 1'b0));
    sb.push_back(mk("sat_1000", 16'h1000, 1'b1, 1'b0));
    sb.push_back(mk("sat_9599", 16'h9599, 1'b1, 1'b0));
    sb.push_back(mk("sat_hold", 16'h9599, 1'b0, 1'b1));
    sb.push_back(mk("sat_ss_ignored", 16'h9599, 1'b0, 1'b1));
    sb.push_back(mk("sat_still_stop", 16'h9599, 1'b0, 1'b1));
    sb.push_back(mk("sat_clear", 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: cyc(4 * 599);
        1: cyc(4);
        2: cyc(4 * (5999 - 600));
        3: cyc(4);
        4: pulse_ss();
        5: cyc(10);
        default: pulse_clr();
      endcase
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
  endtask

  task automatic test_pause();
    pulse_ss();
    cyc(5);
    sb.push_back(mk("pause_stop", 16'h0001, 1'b0, 1'b0));
    sb.push_back(mk("pause_held", 16'h0001, 1'b0, 1'b0));
    sb.push_back(mk("pause_resume", 16'h0001, 1'b1, 1'b0));
    sb.push_back(mk("pause_resume_c1", 16'h0001, 1'b1, 1'b0));
    sb.push_back(mk("pause_resume_c2", 16'h0002, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: pulse_ss();
        1: cyc(100);
        2: pulse_ss();
        default: cyc(1);
      endcase
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
    pulse_clr();
  endtask

  task automatic test_ss_clr();
    pulse_ss();
    cyc(6);
    sb.push_back(mk("ssclr_idle", 16'h0000, 1'b0, 1'b0));
    sb.push_back(mk("ssclr_stays_idle", 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        ss = 1'b1; clr = 1'b1; cyc(1); ss = 1'b0; clr = 1'b0;
      end else begin
        cyc(8);
      end
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_ss();
    cyc(5);
    sb.push_back(mk("async_pre", 16'h0001, 1'b1, 1'b0));
    sb.push_back(mk("async_reset_now", 16'h0000, 1'b0, 1'b0));
    sb.push_back(mk("async_after_release", 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        #2 r = 1'b1;
        #1;
      end else if (i == 2) begin
        #2 r = 1'b0;
        cyc(6);
      end
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
  endtask

`ifdef LAP_EN
  task automatic test_lap();
    pulse_clr();
    pulse_ss();
    sb.push_back(mk("lap_live_012", 16'h0012, 1'b1, 1'b0));
    sb.push_back(mk("lap_frozen", 16'h0012, 1'b1, 1'b0));
    sb.push_back(mk("lap_frozen_20", 16'h0012, 1'b1, 1'b0));
    sb.push_back(mk("lap_release", 16'h0017, 1'b1, 1'b0));
    sb.push_back(mk("lap_idle_ignored", 16'h0001, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: cyc(48);
        1: begin lap = 1'b1; cyc(1); lap = 1'b0; end
        2: cyc(20);
        3: begin lap = 1'b1; cyc(1); lap = 1'b0; end
        default: begin
          pulse_clr();
          lap = 1'b1; cyc(1); lap = 1'b0;
          pulse_ss();
          cyc(4);
        end
      endcase
      e = sb.pop_front(); checks++;
      if ({d3, d2, d1, d0, running, ovf} !== {e.dig, e.run, e.ov}) begin
        errors++;
        $display("FAIL %s got %h run=%b ovf=%b want %h run=%b ovf=%b",
                 e.name, {d3, d2, d1, d0}, running, ovf, e.dig, e.run, e.ov);
      end
    end
    pulse_clr();
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_saturate();
    test_pause();
    test_ss_clr();
    test_async_reset();
`ifdef LAP_EN
    test_lap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout got running sim want finish");
    $fatal(1, "timeout");
  end

endmodule
